// File: rtl/aurora_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// aurora_rx_frame_checker
//
// Receive-side checker for the Aurora user RX AXI-Stream. It is the counterpart
// of the TX incrementing-word frame generator. The checker locks onto the
// incrementing data sequence and then checks every beat for data value, tkeep
// and tlast position.
//
// Ports:
//   user_clk         in   user clock from the Aurora core (rising edge)
//   reset            in   synchronous, active-high reset
//   channel_up       in   Aurora channel_up; low forces the link-wait state
//   m_axi_rx_tdata   in   RX data word
//   m_axi_rx_tkeep   in   RX byte enables
//   m_axi_rx_tvalid  in   RX valid (no tready: every valid beat is consumed)
//   m_axi_rx_tlast   in   end of frame
//   clear            in   synchronous clear of frame_count and error_count
//   locked           out  checker is in the CHECK state
//   frame_count      out  frames completed while locked (wraps)
//   error_count      out  erroneous beats seen while locked (saturates)
//   err_pulse        out  one-cycle strobe the cycle after an erroneous beat
//   expected_data    out  next expected data word
// -----------------------------------------------------------------------------
module aurora_rx_frame_checker #(
    parameter int DATA_W      = 32,
    parameter int FRAME_BEATS = 1,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic                  user_clk,
    input  logic                  reset,
    input  logic                  channel_up,
    input  logic [DATA_W-1:0]     m_axi_rx_tdata,
    input  logic [DATA_W/8-1:0]   m_axi_rx_tkeep,
    input  logic                  m_axi_rx_tvalid,
    input  logic                  m_axi_rx_tlast,
    input  logic                  clear,
    output logic                  locked,
    output logic [31:0]           frame_count,
    output logic [ERR_W-1:0]      error_count,
    output logic                  err_pulse,
    output logic [DATA_W-1:0]     expected_data
);

    localparam int IDX_W  = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME_BEATS - 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS_THRESH);

    typedef enum logic [1:0] {
        WAIT_LINK = 2'd0,
        HUNT      = 2'd1,
        CHECK     = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   beat_idx;
    logic [MISS_W-1:0]  miss_run;
    logic [MISS_W-1:0]  miss_inc;

    logic keep_full;
    logic idx_at_last;
    logic lock_beat;
    logic check_beat;
    logic data_err;
    logic keep_err;
    logic last_err;
    logic beat_err;
    logic miss_hit;

    // -------------------------------------------------------------------------
    // Beat classification
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a value on every path
    // (here unconditionally), otherwise synthesis infers a latch.
    always_comb begin
        keep_full   = &m_axi_rx_tkeep;
        idx_at_last = (beat_idx == LAST_IDX);

        // channel_up low overrides everything, so beats in that cycle are ignored.
        lock_beat  = channel_up && (state == HUNT) && m_axi_rx_tvalid &&
                     m_axi_rx_tlast && keep_full;
        check_beat = channel_up && (state == CHECK) && m_axi_rx_tvalid;

        data_err = (m_axi_rx_tdata != expected_data);
        keep_err = !keep_full;
        last_err = (m_axi_rx_tlast != idx_at_last);

        // Several error types on one beat still count as a single error.
        beat_err = check_beat && (data_err || keep_err || last_err);

        miss_inc = miss_run + MISS_W'(1);
        miss_hit = check_beat && data_err && (miss_inc == MISS_LIMIT);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            state <= WAIT_LINK;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (!channel_up) begin
            state_next = WAIT_LINK;
        end else begin
            case (state)
                WAIT_LINK: state_next = HUNT;
                HUNT:      if (lock_beat) state_next = CHECK;
                CHECK:     if (miss_hit)  state_next = HUNT;
                default:   state_next = WAIT_LINK;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (state is registered, so locked follows the beat by a cycle)
    // -------------------------------------------------------------------------
    always_comb begin
        locked = (state == CHECK);
    end

    // -------------------------------------------------------------------------
    // Datapath: expected word, beat index, miss run, counters, error strobe
    // -------------------------------------------------------------------------
    always_ff @(posedge user_clk) begin
        if (reset) begin
            expected_data <= '0;
            beat_idx      <= '0;
            miss_run      <= '0;
            frame_count   <= '0;
            error_count   <= '0;
            err_pulse     <= 1'b0;
        end else begin
            err_pulse <= beat_err;

            // Advance even on a mismatch so one corrupted word costs one error.
            if (lock_beat) begin
                expected_data <= m_axi_rx_tdata + DATA_W'(1);
            end else if (check_beat) begin
                expected_data <= expected_data + DATA_W'(1);
            end

            // A tlast anywhere resynchronises the index to the frame start.
            if (!channel_up || lock_beat) begin
                beat_idx <= '0;
            end else if (check_beat) begin
                if (m_axi_rx_tlast || idx_at_last) begin
                    beat_idx <= '0;
                end else begin
                    beat_idx <= beat_idx + IDX_W'(1);
                end
            end

            // Counts consecutive data mismatches; cleared when lock is lost.
            if (!channel_up) begin
                miss_run <= '0;
            end else if (check_beat) begin
                if (!data_err || miss_hit) begin
                    miss_run <= '0;
                end else begin
                    miss_run <= miss_inc;
                end
            end

            // clear has priority over a coincident count event.
            if (clear) begin
                frame_count <= '0;
            end else if (check_beat && m_axi_rx_tlast) begin
                frame_count <= frame_count + 32'd1;
            end

            if (clear) begin
                error_count <= '0;
            end else if (beat_err && !(&error_count)) begin
                error_count <= error_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aurora_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_aurora_rx_frame_checker
//
// Two checker instances share one stimulus stream: dut_a has one beat per
// frame, dut_b two beats per frame. Directed scenario tasks check against
// known values; the random task checks both instances every cycle against a
// behavioural model of the checker rules.
// -----------------------------------------------------------------------------
module tb_aurora_rx_frame_checker;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int EW = 16;
    localparam logic [KW-1:0] FULL = '1;

    logic          user_clk = 1'b0;
    logic          reset = 1'b1;
    logic          channel_up = 1'b0;
    logic          clear = 1'b0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic [KW-1:0] tkeep = '1;

    logic          lk [2];
    logic [31:0]   fc [2];
    logic [EW-1:0] ec [2];
    logic          pu [2];
    logic [DW-1:0] ex [2];

    int vectors     = 0;
    int miscompares = 0;
    int pulse_seen [2] = '{0, 0};

    // Reference model state, one slot per instance.
    int          m_mode [2];   // 0 = waiting for link, 1 = hunting, 2 = checking
    bit [DW-1:0] m_exp  [2];
    bit [31:0]   m_fc   [2];
    bit [EW-1:0] m_ec   [2];
    bit          m_pu   [2];
    int          m_idx  [2];
    int          m_miss [2];

    always #5 user_clk = ~user_clk;

    aurora_rx_frame_checker #(
        .DATA_W(DW), .FRAME_BEATS(1), .LOSS_THRESH(4), .ERR_W(EW)
    ) dut_a (
        .user_clk(user_clk), .reset(reset), .channel_up(channel_up),
        .m_axi_rx_tdata(tdata), .m_axi_rx_tkeep(tkeep),
        .m_axi_rx_tvalid(tvalid), .m_axi_rx_tlast(tlast), .clear(clear),
        .locked(lk[0]), .frame_count(fc[0]), .error_count(ec[0]),
        .err_pulse(pu[0]), .expected_data(ex[0])
    );

    aurora_rx_frame_checker #(
        .DATA_W(DW), .FRAME_BEATS(2), .LOSS_THRESH(4), .ERR_W(EW)
    ) dut_b (
        .user_clk(user_clk), .reset(reset), .channel_up(channel_up),
        .m_axi_rx_tdata(tdata), .m_axi_rx_tkeep(tkeep),
        .m_axi_rx_tvalid(tvalid), .m_axi_rx_tlast(tlast), .clear(clear),
        .locked(lk[1]), .frame_count(fc[1]), .error_count(ec[1]),
        .err_pulse(pu[1]), .expected_data(ex[1])
    );

    // One clock of the checker rules for instance i with fb beats per frame.
    function automatic void model_step(input int i, input int fb);
        bit de;
        bit err;
        if (reset) begin
            m_mode[i] = 0; m_exp[i] = '0; m_fc[i] = '0; m_ec[i] = '0;
            m_pu[i] = 1'b0; m_idx[i] = 0; m_miss[i] = 0;
            return;
        end
        m_pu[i] = 1'b0;
        if (!channel_up) begin
            m_mode[i] = 0; m_idx[i] = 0; m_miss[i] = 0;
        end else if (m_mode[i] == 0) begin
            m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
            if (tvalid && tlast && tkeep == FULL) begin
                m_exp[i] = tdata + 32'd1; m_idx[i] = 0; m_mode[i] = 2;
            end
        end else if (tvalid) begin
            de  = (tdata != m_exp[i]);
            err = de || (tkeep != FULL) || (tlast != (m_idx[i] == fb - 1));
            m_exp[i] = m_exp[i] + 32'd1;
            m_idx[i] = (tlast || m_idx[i] == fb - 1) ? 0 : m_idx[i] + 1;
            if (tlast) m_fc[i] = m_fc[i] + 32'd1;
            if (err) begin
                if (m_ec[i] != '1) m_ec[i] = m_ec[i] + 16'd1;
                m_pu[i] = 1'b1;
            end
            m_miss[i] = de ? m_miss[i] + 1 : 0;
            if (m_miss[i] == 4) begin
                m_mode[i] = 1; m_miss[i] = 0;
            end
        end
        if (clear) begin
            m_fc[i] = '0; m_ec[i] = '0;
        end
    endfunction

    // Drive one clock of stimulus; outputs are settled #1 after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d,
                         input logic [KW-1:0] k, input logic l);
        @(negedge user_clk);
        tvalid = v; tdata = d; tkeep = k; tlast = l;
        @(posedge user_clk);
        model_step(0, 1);
        model_step(1, 2);
        #1;
        for (int i = 0; i < 2; i++) if (pu[i] === 1'b1) pulse_seen[i]++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle(1'b0, '0, FULL, 1'b0);
    endtask

    task automatic send(input logic [DW-1:0] d);
        cycle(1'b1, d, FULL, 1'b1);
    endtask

    task automatic restart();
        reset = 1'b1; channel_up = 1'b0; clear = 1'b0;
        idle(2);
        reset = 1'b0; channel_up = 1'b1;
        idle(1);
        pulse_seen = '{0, 0};
    endtask

    task automatic test_reset();
        reset = 1'b1; channel_up = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 2; i++) begin
            vectors++; if (lk[i] !== 1'b0) begin miscompares++; $display("FAIL reset_locked[%0d]: got %b want 0", i, lk[i]); end
            vectors++; if (fc[i] !== 32'd0) begin miscompares++; $display("FAIL reset_frame_count[%0d]: got %0d want 0", i, fc[i]); end
            vectors++; if (ec[i] !== 16'd0) begin miscompares++; $display("FAIL reset_error_count[%0d]: got %0d want 0", i, ec[i]); end
            vectors++; if (pu[i] !== 1'b0) begin miscompares++; $display("FAIL reset_err_pulse[%0d]: got %b want 0", i, pu[i]); end
            vectors++; if (ex[i] !== 32'd0) begin miscompares++; $display("FAIL reset_expected[%0d]: got %h want 0", i, ex[i]); end
        end
    endtask

    task automatic test_sequence();
        restart();
        send(32'd1);
        vectors++; if (lk[0] !== 1'b1) begin miscompares++; $display("FAIL seq_lock: got %b want 1", lk[0]); end
        vectors++; if (fc[0] !== 32'd0) begin miscompares++; $display("FAIL seq_lock_frames: got %0d want 0", fc[0]); end
        idle(5);
        for (int v = 2; v <= 100; v++) begin
            send(DW'(v));
            idle(5);
        end
        vectors++; if (fc[0] !== 32'd99) begin miscompares++; $display("FAIL seq_frame_count: got %0d want 99", fc[0]); end
        vectors++; if (ec[0] !== 16'd0) begin miscompares++; $display("FAIL seq_error_count: got %0d want 0", ec[0]); end
        vectors++; if (pulse_seen[0] !== 0) begin miscompares++; $display("FAIL seq_err_pulses: got %0d want 0", pulse_seen[0]); end
        vectors++; if (ex[0] !== 32'd101) begin miscompares++; $display("FAIL seq_expected: got %h want 65", ex[0]); end
    endtask

    task automatic test_single_corruption();
        restart();
        send(32'h10);
        for (int v = 'h11; v <= 'h30; v++) begin
            send((v == 'h20) ? 32'hDEAD : DW'(v));
            if (v == 'h21) begin
                vectors++; if (ec[0] !== 16'd1) begin miscompares++; $display("FAIL corrupt_after_21: got %0d want 1", ec[0]); end
                vectors++; if (pu[0] !== 1'b0) begin miscompares++; $display("FAIL corrupt_pulse_21: got %b want 0", pu[0]); end
            end
        end
        vectors++; if (ec[0] !== 16'd1) begin miscompares++; $display("FAIL corrupt_errors: got %0d want 1", ec[0]); end
        vectors++; if (pulse_seen[0] !== 1) begin miscompares++; $display("FAIL corrupt_pulses: got %0d want 1", pulse_seen[0]); end
        vectors++; if (lk[0] !== 1'b1) begin miscompares++; $display("FAIL corrupt_locked: got %b want 1", lk[0]); end
        vectors++; if (fc[0] !== 32'd32) begin miscompares++; $display("FAIL corrupt_frames: got %0d want 32", fc[0]); end
    endtask

    task automatic test_sequence_jump();
        restart();
        for (int v = 1; v <= 10; v++) send(DW'(v));
        for (int v = 'h500; v <= 'h510; v++) begin
            send(DW'(v));
            if (v == 'h502) begin
                vectors++; if (lk[0] !== 1'b1) begin miscompares++; $display("FAIL jump_still_locked: got %b want 1", lk[0]); end
            end
            if (v == 'h503) begin
                vectors++; if (lk[0] !== 1'b0) begin miscompares++; $display("FAIL jump_unlock: got %b want 0", lk[0]); end
                vectors++; if (ec[0] !== 16'd4) begin miscompares++; $display("FAIL jump_errors_at_loss: got %0d want 4", ec[0]); end
            end
            if (v == 'h504) begin
                vectors++; if (lk[0] !== 1'b1) begin miscompares++; $display("FAIL jump_relock: got %b want 1", lk[0]); end
                vectors++; if (ex[0] !== 32'h505) begin miscompares++; $display("FAIL jump_expected: got %h want 505", ex[0]); end
            end
        end
        vectors++; if (ec[0] !== 16'd4) begin miscompares++; $display("FAIL jump_errors: got %0d want 4", ec[0]); end
        vectors++; if (fc[0] !== 32'd25) begin miscompares++; $display("FAIL jump_frames: got %0d want 25", fc[0]); end
        vectors++; if (ex[0] !== 32'h511) begin miscompares++; $display("FAIL jump_expected_end: got %h want 511", ex[0]); end
    endtask

    task automatic test_keep_last();
        restart();
        send(32'd1);
        cycle(1'b1, 32'd2, 4'b0111, 1'b1);
        vectors++; if (ec[0] !== 16'd1) begin miscompares++; $display("FAIL keep_error: got %0d want 1", ec[0]); end
        vectors++; if (pu[0] !== 1'b1) begin miscompares++; $display("FAIL keep_pulse: got %b want 1", pu[0]); end
        send(32'd3);
        vectors++; if (ec[0] !== 16'd1) begin miscompares++; $display("FAIL keep_next_ok: got %0d want 1", ec[0]); end
        vectors++; if (pu[0] !== 1'b0) begin miscompares++; $display("FAIL keep_pulse_drop: got %b want 0", pu[0]); end

        // Two-beat frames on dut_b.
        restart();
        send(32'd1);
        cycle(1'b1, 32'd2, FULL, 1'b0);
        cycle(1'b1, 32'd3, FULL, 1'b1);
        vectors++; if (ec[1] !== 16'd0) begin miscompares++; $display("FAIL last_clean_frame: got %0d want 0", ec[1]); end
        cycle(1'b1, 32'd4, FULL, 1'b1);
        vectors++; if (ec[1] !== 16'd1) begin miscompares++; $display("FAIL last_early: got %0d want 1", ec[1]); end
        cycle(1'b1, 32'd5, FULL, 1'b0);
        cycle(1'b1, 32'd6, FULL, 1'b1);
        vectors++; if (ec[1] !== 16'd1) begin miscompares++; $display("FAIL last_resync: got %0d want 1", ec[1]); end
        cycle(1'b1, 32'd7, 4'b0111, 1'b1);
        vectors++; if (ec[1] !== 16'd2) begin miscompares++; $display("FAIL keep_and_last_once: got %0d want 2", ec[1]); end
        cycle(1'b1, 32'd8, FULL, 1'b0);
        cycle(1'b1, 32'd9, FULL, 1'b1);
        vectors++; if (ec[1] !== 16'd2) begin miscompares++; $display("FAIL last_end_errors: got %0d want 2", ec[1]); end
        vectors++; if (pulse_seen[1] !== 2) begin miscompares++; $display("FAIL last_pulses: got %0d want 2", pulse_seen[1]); end
        vectors++; if (fc[1] !== 32'd5) begin miscompares++; $display("FAIL last_frames: got %0d want 5", fc[1]); end
    endtask

    task automatic test_link_drop();
        restart();
        for (int v = 1; v <= 38; v++) send(DW'(v));
        vectors++; if (fc[0] !== 32'd37) begin miscompares++; $display("FAIL drop_before: got %0d want 37", fc[0]); end
        channel_up = 1'b0;
        send(32'd39);
        vectors++; if (lk[0] !== 1'b0) begin miscompares++; $display("FAIL drop_unlock: got %b want 0", lk[0]); end
        vectors++; if (fc[0] !== 32'd37) begin miscompares++; $display("FAIL drop_frames: got %0d want 37", fc[0]); end
        send(32'd40);
        vectors++; if (fc[0] !== 32'd37) begin miscompares++; $display("FAIL drop_frames_held: got %0d want 37", fc[0]); end
        vectors++; if (ec[0] !== 16'd0) begin miscompares++; $display("FAIL drop_errors: got %0d want 0", ec[0]); end
        channel_up = 1'b1;
        idle(1);
        send(32'h777);
        vectors++; if (lk[0] !== 1'b1) begin miscompares++; $display("FAIL drop_relock: got %b want 1", lk[0]); end
        vectors++; if (ex[0] !== 32'h778) begin miscompares++; $display("FAIL drop_expected: got %h want 778", ex[0]); end
        vectors++; if (fc[0] !== 32'd37) begin miscompares++; $display("FAIL drop_frames_relock: got %0d want 37", fc[0]); end
    endtask

    task automatic test_wrap_clear();
        restart();
        send(32'hFFFF_FFFE);
        send(32'hFFFF_FFFF);
        send(32'h0);
        send(32'h1);
        vectors++; if (ec[0] !== 16'd0) begin miscompares++; $display("FAIL wrap_errors: got %0d want 0", ec[0]); end
        vectors++; if (fc[0] !== 32'd3) begin miscompares++; $display("FAIL wrap_frames: got %0d want 3", fc[0]); end
        vectors++; if (ex[0] !== 32'd2) begin miscompares++; $display("FAIL wrap_expected: got %h want 2", ex[0]); end
        send(32'hBAD);
        vectors++; if (ec[0] !== 16'd1) begin miscompares++; $display("FAIL wrap_bad: got %0d want 1", ec[0]); end
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        vectors++; if (fc[0] !== 32'd0) begin miscompares++; $display("FAIL clear_frames: got %0d want 0", fc[0]); end
        vectors++; if (ec[0] !== 16'd0) begin miscompares++; $display("FAIL clear_errors: got %0d want 0", ec[0]); end
        vectors++; if (lk[0] !== 1'b1) begin miscompares++; $display("FAIL clear_locked: got %b want 1", lk[0]); end
        clear = 1'b1;
        send(32'd3);
        clear = 1'b0;
        vectors++; if (fc[0] !== 32'd0) begin miscompares++; $display("FAIL clear_wins: got %0d want 0", fc[0]); end
        vectors++; if (ex[0] !== 32'd4) begin miscompares++; $display("FAIL clear_expected: got %h want 4", ex[0]); end
        send(32'd4);
        vectors++; if (fc[0] !== 32'd1) begin miscompares++; $display("FAIL clear_recount: got %0d want 1", fc[0]); end
    endtask

    task automatic test_random();
        int burst = 0;
        logic          v;
        logic          l;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        restart();
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 999) < 2);
            if (channel_up) channel_up = ($urandom_range(0, 299) != 0);
            else            channel_up = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 149) == 0);
            if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(2, 6);
            v = ($urandom_range(0, 9) < 7);
            if (burst > 0) begin
                d = $urandom;
                if (v) burst--;
            end else begin
                case ($urandom_range(0, 19))
                    0:       d = $urandom;
                    1:       d = m_exp[0] + 32'h100;
                    2:       d = m_exp[1];
                    default: d = m_exp[0];
                endcase
            end
            k = ($urandom_range(0, 29) == 0) ? KW'($urandom) : FULL;
            l = ($urandom_range(0, 3) != 0);
            cycle(v, d, k, l);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({lk[i], pu[i], fc[i], ec[i], ex[i]} !==
                    {(m_mode[i] == 2), m_pu[i], m_fc[i], m_ec[i], m_exp[i]}) begin
                    miscompares++;
                    $display("FAIL random[%0d] cycle %0d: got lk=%b pu=%b fc=%0d ec=%0d ex=%h want lk=%b pu=%b fc=%0d ec=%0d ex=%h",
                             i, n, lk[i], pu[i], fc[i], ec[i], ex[i],
                             (m_mode[i] == 2), m_pu[i], m_fc[i], m_ec[i], m_exp[i]);
                end
            end
        end
        reset = 1'b0;
        clear = 1'b0;
        channel_up = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_single_corruption();
        test_sequence_jump();
        test_keep_last();
        test_link_drop();
        test_wrap_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
